// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan decoder and its companion
// display encoder:
//   GLYPH    - 16-entry active-low glyph table, light[6]=a ... light[0]=g
//   BLANK    - all segments dark
//   EN_NONE  - no digit selected
//   state_t  - scan decoder FSM encoding
//   en_valid / en_index - one-cold digit-select helpers
// ---------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] BLANK   = 7'h7F;
   localparam logic [3:0] EN_NONE = 4'hF;

   // Index is the hex value shown by the glyph. Segment order is a..g, MSB first.
   localparam logic [6:0] GLYPH [0:15] = '{
      7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
      7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
      7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
      7'h31, 7'h42, 7'h30, 7'h38    // C d E F
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // A digit is selected only when exactly one enable line is pulled low.
   function automatic logic en_valid(input logic [3:0] en);
      return (en == 4'b1110) || (en == 4'b1101) ||
             (en == 4'b1011) || (en == 4'b0111);
   endfunction

   // Position of the low bit; only meaningful when en_valid() is true.
   function automatic logic [1:0] en_index(input logic [3:0] en);
      logic [1:0] idx;
      idx = 2'd0;
      if (!en[1]) idx = 2'd1;
      if (!en[2]) idx = 2'd2;
      if (!en[3]) idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational reverse lookup of an active-low segment pattern in the glyph
// table.
//   light  in  7  active-low segments, light[6]=a ... light[0]=g
//   nibble out 4  hex value of the matching glyph (0 when no match)
//   hit    out 1  pattern is one of the 16 hex glyphs
// ---------------------------------------------------------------------------
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] light,
   output logic [3:0] nibble,
   output logic       hit
);

   always_comb begin
      // NOTE: every output gets a default before the search so no path through
      // the loop leaves a value unassigned and a latch is never inferred.
      nibble = 4'h0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (light == GLYPH[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Recovers the four hex digits shown on a multiplexed, active-low seven
// segment display by watching its segment and digit-enable lines.
//   clk         in   1  system clock, rising edge
//   reset       in   1  synchronous, active-high
//   enable      in   1  high = decoding active; low = FSM idle, outputs held
//   light       in   7  active-low segments, light[6]=a ... light[0]=g
//   en          in   4  active-low digit select, en[0] = rightmost digit
//   digits      out 16  last complete frame, digits[4i+3:4i] = digit i
//   frame_done  out  1  one-cycle pulse when digits updates
//   seen        out  4  digits accepted since the last frame
//   bad_pattern out  1  sticky, an accepted pattern was not a hex glyph
// A (light, en) pair must be sampled SETTLE times in a row before it is
// accepted; the scan is then held without re-capture until the inputs change.
// ---------------------------------------------------------------------------
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned SETTLE = 4   // 2..255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [6:0]  light,
   input  logic [3:0]  en,
   output logic [15:0] digits,
   output logic        frame_done,
   output logic [3:0]  seen,
   output logic        bad_pattern
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic [6:0]  light_q, light_p;   // current and previous sample
   logic [3:0]  en_q, en_p;
   logic [3:0]  slot [0:3];         // working digits of the frame being built
   logic [3:0]  seen_n;
   logic [3:0]  nibble;
   logic        hit;
   logic        capture;
   logic        frame_copy;
   logic        sel_valid;
   logic        same;
   logic [1:0]  sel;

   seg7_pattern_decode u_decode (
      .light  (light_q),
      .nibble (nibble),
      .hit    (hit)
   );

   assign sel_valid = en_valid(en_q);
   assign sel       = en_index(en_q);
   assign same      = (light_q == light_p) && (en_q == en_p);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      if (!enable) begin
         state_n = ST_IDLE;
         cnt_n   = 8'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (sel_valid) begin
                  state_n = ST_SETTLE;
                  cnt_n   = 8'd1;
               end
            end
            ST_SETTLE: begin
               if (!sel_valid) begin
                  state_n = ST_IDLE;
                  cnt_n   = 8'd0;
               end else if (!same) begin
                  cnt_n = 8'd1;
               end else if (cnt >= SETTLE_C - 8'd1) begin
                  // Count saturates at SETTLE and stays there through HOLD.
                  capture = 1'b1;
                  state_n = ST_HOLD;
                  cnt_n   = SETTLE_C;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            ST_HOLD: begin
               if (!sel_valid) begin
                  state_n = ST_IDLE;
                  cnt_n   = 8'd0;
               end else if (!same) begin
                  state_n = ST_SETTLE;
                  cnt_n   = 8'd1;
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = 8'd0;
            end
         endcase
      end
   end

   // Frame copy clears seen first, so a capture in the same cycle counts
   // toward the next frame.
   always_comb begin
      frame_copy = enable && (seen == 4'hF);
      seen_n     = frame_copy ? 4'h0 : seen;
      if (capture && hit) seen_n[sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge value of every other register (sample -> previous).
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= 8'd0;
         light_q     <= BLANK;
         light_p     <= BLANK;
         en_q        <= EN_NONE;
         en_p        <= EN_NONE;
         digits      <= 16'h0000;
         seen        <= 4'h0;
         frame_done  <= 1'b0;
         bad_pattern <= 1'b0;
         // NOTE: the four working slots are flops, not RAM, so clearing them
         // here is cheap and makes the first frame deterministic.
         for (int i = 0; i < 4; i++) slot[i] <= 4'h0;
      end else begin
         light_q    <= light;
         en_q       <= en;
         light_p    <= light_q;
         en_p       <= en_q;
         state      <= state_n;
         cnt        <= cnt_n;
         seen       <= seen_n;
         frame_done <= frame_copy;
         if (frame_copy) digits <= {slot[3], slot[2], slot[1], slot[0]};
         if (capture) begin
            if (hit) slot[sel] <= nibble;
            else     bad_pattern <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder with SETTLE=4. Inputs are driven and
// outputs checked on the falling edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [6:0]  light;
   logic [3:0]  en;
   logic [15:0] digits;
   logic        frame_done;
   logic [3:0]  seen;
   logic        bad_pattern;

   int errors;
   int checks;
   int frames;

   seg7_scan_decoder #(.SETTLE(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .light       (light),
      .en          (en),
      .digits      (digits),
      .frame_done  (frame_done),
      .seen        (seen),
      .bad_pattern (bad_pattern)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A one-cycle pulse is counted exactly once per high cycle.
   always @(negedge clk) if (frame_done === 1'b1) frames++;

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic [3:0] e, input logic [6:0] l);
      en    = e;
      light = l;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      frames = 0;
      reset  = 1'b1;
      enable = 1'b1;
      drive(4'hF, 7'h7F);
      run(3);
      reset = 1'b0;
      run(1);

      // Reset state
      check("rst_digits", 32'(digits), 32'h0000);
      check("rst_seen", 32'(seen), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      check("rst_bad", 32'(bad_pattern), 32'h0);

      // Scan 1,2,3,4; first digit also checks SETTLE+1 latency
      drive(4'b1110, 7'h4F);
      run(4);
      check("lat_before", 32'(seen), 32'h0);
      run(1);
      check("lat_capture", 32'(seen), 32'h1);
      run(3);
      drive(4'b1101, 7'h12);
      run(8);
      check("scan_seen2", 32'(seen), 32'h3);
      drive(4'b1011, 7'h06);
      run(8);
      drive(4'b0111, 7'h4C);
      run(5);
      check("scan_seen_full", 32'(seen), 32'hF);
      check("scan_no_frame_yet", 32'(frames), 32'd0);
      run(1);
      check("scan_pulse", 32'(frame_done), 32'h1);
      check("scan_digits", 32'(digits), 32'h4321);
      check("scan_seen_clr", 32'(seen), 32'h0);
      run(2);
      check("scan_pulse_end", 32'(frame_done), 32'h0);
      check("scan_frames", 32'(frames), 32'd1);

      // Glitch: pattern changes every 2 cycles, never settles
      for (int i = 0; i < 10; i++) begin
         drive(4'b1110, (i % 2 == 0) ? 7'h4F : 7'h12);
         run(2);
      end
      check("glitch_seen", 32'(seen), 32'h0);
      check("glitch_frames", 32'(frames), 32'd1);

      // Blank on digit 2
      drive(4'b1011, 7'h7F);
      run(10);
      check("blank_bad", 32'(bad_pattern), 32'h1);
      check("blank_seen", 32'(seen), 32'h0);
      check("blank_digits", 32'(digits), 32'h4321);

      // Digit 0 re-captured: latest value wins; frame F,8,A,1
      drive(4'b1110, 7'h01);
      run(8);
      check("ovr_seen0", 32'(seen), 32'h1);
      drive(4'b1110, 7'h4F);
      run(8);
      drive(4'b1101, 7'h08);
      run(8);
      drive(4'b1011, 7'h00);
      run(8);
      drive(4'b0111, 7'h38);
      run(8);
      check("ovr_digits", 32'(digits), 32'hF8A1);
      check("ovr_frames", 32'(frames), 32'd2);
      check("ovr_bad_sticky", 32'(bad_pattern), 32'h1);

      // Reset two cycles into settling on digit 1
      drive(4'b1101, 7'h12);
      run(2);
      reset = 1'b1;
      run(1);
      check("mid_rst_digits", 32'(digits), 32'h0000);
      check("mid_rst_seen", 32'(seen), 32'h0);
      check("mid_rst_bad", 32'(bad_pattern), 32'h0);
      check("mid_rst_frame_done", 32'(frame_done), 32'h0);
      reset = 1'b0;
      run(4);
      check("mid_rst_no_partial", 32'(seen), 32'h0);
      run(1);
      check("mid_rst_recapture", 32'(seen), 32'h2);

      // enable low: nothing captured while inputs are stable
      enable = 1'b0;
      drive(4'b1110, 7'h06);
      run(20);
      check("dis_seen", 32'(seen), 32'h2);
      check("dis_digits", 32'(digits), 32'h0000);
      enable = 1'b1;
      run(3);
      check("en_resume_wait", 32'(seen), 32'h2);
      run(1);
      check("en_resume_cap", 32'(seen), 32'h3);

      // Two enables low is not a digit
      drive(4'b1100, 7'h12);
      run(10);
      check("multi_en_seen", 32'(seen), 32'h3);
      check("multi_en_frames", 32'(frames), 32'd2);
      check("multi_en_bad", 32'(bad_pattern), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive identical samples (en, light) needed to accept a digit, range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  high = decoding active; low = FSM forced to IDLE, outputs held.
REQ-005 SHALL have port light  input  7  active-low segments, light[6]=a ... light[0]=g.
REQ-006 SHALL have port en  input  4  active-low digit select, en[0]=rightmost digit.
REQ-007 SHALL have port digits  output  16  last complete frame, digits[4i+3:4i] = digit i.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when digits updates.
REQ-009 SHALL have port seen  output  4  per-digit accepted-since-last-frame flags.
REQ-010 SHALL have port bad_pattern  output  1  sticky; set on an accepted non-hex pattern.

Function
REQ-011 SHALL register light and en once on entry (sample stage); all decisions use registered values; latency from stable input to capture = SETTLE+1 cycles.
REQ-012 SHALL treat en as valid only when exactly one bit is 0 (4'b1110, 1101, 1011, 0111); any other value is "no digit".
REQ-013 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-014 IDLE: on valid en -> SETTLE with counter=1; else stay.
REQ-015 SETTLE: sample equal to previous -> counter+1; counter reaching SETTLE -> capture, go HOLD; sample differs with valid en -> counter=1, stay; invalid en -> IDLE.
REQ-016 HOLD: stay while sample unchanged (no re-capture); change with valid en -> SETTLE counter=1; invalid en -> IDLE.
REQ-017 Capture SHALL decode light to a nibble for the 16 hex glyphs (0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 8=7'h00, A=7'h08, remaining per package table), store it in the working slot of the selected digit, and set seen[i].
REQ-018 Capture of a non-hex pattern (including blank 7'h7F) SHALL set bad_pattern, leave the slot and seen[i] unchanged.
REQ-019 When seen becomes 4'hF, the next cycle SHALL copy the four working slots to digits, pulse frame_done for exactly one cycle, and clear seen to 0.
REQ-020 A capture in the same cycle as the frame copy SHALL be applied after clearing (that digit's seen bit set in the new frame).
REQ-021 Re-capture of an already-seen digit before frame completion SHALL overwrite its slot (latest value wins).
REQ-022 Counter SHALL saturate at SETTLE; no wrap.
REQ-023 enable low SHALL force IDLE, zero the counter, suppress capture and frame_done; digits, seen, bad_pattern hold.

Reset
REQ-024 reset SHALL set state=IDLE, counter=0, sample registers to light=7'h7F en=4'hF, working slots=0, digits=16'h0000, seen=4'h0, frame_done=0, bad_pattern=0.
REQ-025 reset SHALL take priority over enable and any capture or frame copy in the same cycle; reset mid-SETTLE discards the partial count.
REQ-026 bad_pattern SHALL clear only on reset.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the 16-entry active-low glyph table, BLANK=7'h7F, EN_NONE=4'hF, and the FSM state encoding.
REQ-028 Pattern-to-nibble lookup SHALL be a sub-module seg7_pattern_decode (light in; nibble, hit out; combinational) reusable by the display encoder.
REQ-029 Total RTL SHALL fit in 120-400 lines.

Verification
REQ-030 Scan 1,2,3,4 on digits 0..3 (en 1110/1101/1011/0111, 8 cycles each, SETTLE=4) -> frame_done one pulse, digits=16'h4321, seen=0.
REQ-031 Glitch: en=1110, light toggling 7'h4F/7'h12 every 2 cycles for 20 cycles -> no capture, seen=0, no frame_done.
REQ-032 Blank 7'h7F held 10 cycles on digit 2 -> bad_pattern=1, seen[2]=0, digits unchanged.
REQ-033 Digit 0 shows 7'h01 then 7'h4F before other digits complete -> final frame digit 0 = 1.
REQ-034 reset asserted during SETTLE on digit 1 after 2 cycles -> all outputs at REQ-024 values next cycle; enable low for 20 stable cycles -> no capture.
REQ-035 en=4'b1100 for 10 cycles with valid light -> FSM stays IDLE, no seen change.
